// File: rtl/cam_pkt_pkg.sv
// Shared types for the camera line packetizer: FSM states, the 64-bit
// packet header layout and its bit offsets, and the default counter width.
package cam_pkt_pkg;

  localparam int CNT_W_DEF     = 16;

  localparam int HDR_FRAME_LSB = 48;
  localparam int HDR_LINE_LSB  = 32;
  localparam int HDR_CHUNK_LSB = 16;
  localparam int HDR_CONT_BIT  = 1;
  localparam int HDR_SOF_BIT   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } cam_pkt_state_e;

  // Header beat: frame[63:48] line[47:32] chunk[31:16] rsvd[15:2] cont[1] sof[0]
  typedef struct packed {
    logic [15:0] frame;
    logic [15:0] line;
    logic [15:0] chunk;
    logic [13:0] rsvd;
    logic        cont;
    logic        sof;
  } cam_pkt_hdr_t;

  function automatic cam_pkt_hdr_t cam_pkt_hdr_pack(input logic [15:0] frame,
                                                    input logic [15:0] line,
                                                    input logic [15:0] chunk,
                                                    input logic        sof);
    cam_pkt_hdr_t h;
    h.frame = frame;
    h.line  = line;
    h.chunk = chunk;
    h.rsvd  = '0;
    h.cont  = (chunk != 16'd0);
    h.sof   = sof;
    return h;
  endfunction

endpackage

// File: rtl/cam_line_pkt.sv
// Camera line packetizer: splits each AXIS line into packets of at most
// MAX_BEATS payload beats, each preceded by a frame/line/chunk header beat.
// Optional statistics counters are built when CAM_LINE_PKT_STATS_EN is defined.
module cam_line_pkt
  import cam_pkt_pkg::*;
#(
  parameter int MAX_BEATS = 128,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             i_pclk,
  input  logic             i_prst,
  input  logic             i_enable,
  input  logic             i_axis_tvalid,
  input  logic             i_axis_tlast,
  input  logic [63:0]      i_axis_tdata,
  input  logic [7:0]       i_axis_tkeep,
  input  logic [1:0]       i_axis_tuser,
  output logic             o_axis_tready,
  output logic             o_axis_tvalid,
  output logic             o_axis_tlast,
  output logic [63:0]      o_axis_tdata,
  output logic [7:0]       o_axis_tkeep,
  output logic [1:0]       o_axis_tuser,
  input  logic             i_axis_tready,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_line_cnt,
`ifdef CAM_LINE_PKT_STATS_EN
  output logic [31:0]      o_stat_pkts,
  output logic [31:0]      o_stat_drop,
  output logic [15:0]      o_stat_err,
`endif
  output logic             o_err_sof
);

  localparam int BEAT_W = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);

  cam_pkt_state_e state_q, state_d;
  logic [CNT_W-1:0]  frame_q, frame_d;
  logic [CNT_W-1:0]  line_q, line_d;
  logic [CNT_W-1:0]  chunk_q, chunk_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              seen_q, seen_d;
  logic              drop_first_q, drop_first_d;
  logic              err_q, err_d;
  cam_pkt_hdr_t      hdr_q, hdr_d;

  logic [CNT_W-1:0]  sof_frame;
  logic [CNT_W-1:0]  drop_line;
  logic [CNT_W-1:0]  chunk_nxt;

  // The first SOF after reset opens frame 0; every later SOF advances the index.
  function automatic logic [CNT_W-1:0] frame_on_sof(input logic [CNT_W-1:0] frame,
                                                    input logic             seen);
    return seen ? frame + 1'b1 : frame;
  endfunction

  // End of frame resets the line index, otherwise the line index advances.
  function automatic logic [CNT_W-1:0] line_on_last(input logic [CNT_W-1:0] line,
                                                    input logic             eof);
    return eof ? '0 : line + 1'b1;
  endfunction

  assign sof_frame = frame_on_sof(frame_q, seen_q);
  assign chunk_nxt = chunk_q + 1'b1;

  // Next-state, counter updates and the output mux for the current state.
  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    line_d        = line_q;
    chunk_d       = chunk_q;
    beat_d        = beat_q;
    seen_d        = seen_q;
    drop_first_d  = drop_first_q;
    err_d         = 1'b0;
    hdr_d         = hdr_q;
    drop_line     = line_q;
    o_axis_tready = 1'b0;
    o_axis_tvalid = 1'b0;
    o_axis_tlast  = 1'b0;
    o_axis_tdata  = '0;
    o_axis_tkeep  = '0;
    o_axis_tuser  = '0;
    case (state_q)
      IDLE: begin
        if (i_axis_tvalid) begin
          if (i_enable) begin
            state_d = HDR;
            chunk_d = '0;
            if (i_axis_tuser[0]) begin
              frame_d = sof_frame;
              line_d  = '0;
              seen_d  = 1'b1;
              hdr_d   = cam_pkt_hdr_pack(16'(sof_frame), 16'd0, 16'd0, 1'b1);
            end else begin
              hdr_d   = cam_pkt_hdr_pack(16'(frame_q), 16'(line_q), 16'd0, 1'b0);
            end
          end else begin
            state_d      = DROP;
            drop_first_d = 1'b1;
          end
        end
      end
      HDR: begin
        o_axis_tvalid = 1'b1;
        o_axis_tdata  = hdr_q;
        o_axis_tkeep  = 8'hFF;
        o_axis_tuser  = 2'b01;
        if (i_axis_tready) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        o_axis_tvalid = i_axis_tvalid;
        o_axis_tready = i_axis_tready;
        o_axis_tdata  = i_axis_tdata;
        o_axis_tkeep  = i_axis_tkeep;
        o_axis_tuser  = {i_axis_tuser[1], 1'b0};
        o_axis_tlast  = i_axis_tlast | (beat_q == BEAT_LAST);
        if (i_axis_tvalid && i_axis_tready) begin
          beat_d = beat_q + 1'b1;
          // A mid-line SOF is flagged but otherwise ignored.
          if (i_axis_tuser[0] && ((beat_q != '0) || (chunk_q != '0))) begin
            err_d = 1'b1;
          end
          if (i_axis_tlast) begin
            line_d  = line_on_last(line_q, i_axis_tuser[1]);
            chunk_d = '0;
            state_d = IDLE;
          end else if (beat_q == BEAT_LAST) begin
            chunk_d = chunk_nxt;
            hdr_d   = cam_pkt_hdr_pack(hdr_q.frame, hdr_q.line, 16'(chunk_nxt), 1'b0);
            state_d = HDR;
          end
        end
      end
      DROP: begin
        o_axis_tready = 1'b1;
        if (i_axis_tvalid) begin
          drop_first_d = 1'b0;
          if (drop_first_q && i_axis_tuser[0]) begin
            frame_d   = sof_frame;
            seen_d    = 1'b1;
            drop_line = '0;
          end
          line_d = drop_line;
          if (i_axis_tlast) begin
            line_d  = line_on_last(drop_line, i_axis_tuser[1]);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and counters; cleared by reset.
  always_ff @(posedge i_pclk) begin
    if (i_prst) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      line_q       <= '0;
      chunk_q      <= '0;
      beat_q       <= '0;
      seen_q       <= 1'b0;
      drop_first_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      line_q       <= line_d;
      chunk_q      <= chunk_d;
      beat_q       <= beat_d;
      seen_q       <= seen_d;
      drop_first_q <= drop_first_d;
      err_q        <= err_d;
    end
  end

  // Header register; only observed in HDR, which is always loaded first.
  always_ff @(posedge i_pclk) begin
    hdr_q <= hdr_d;
  end

  assign o_frame_cnt = frame_q;
  assign o_line_cnt  = line_q;
  assign o_err_sof   = err_q;

`ifdef CAM_LINE_PKT_STATS_EN
  logic [31:0] stat_pkts_q;
  logic [31:0] stat_drop_q;
  logic [15:0] stat_err_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 1'b1;
  endfunction

  // Saturating packet, dropped-beat and SOF-error counters.
  always_ff @(posedge i_pclk) begin
    if (i_prst) begin
      stat_pkts_q <= '0;
      stat_drop_q <= '0;
      stat_err_q  <= '0;
    end else begin
      if (state_q == HDR && i_axis_tready) stat_pkts_q <= sat_inc32(stat_pkts_q);
      if (state_q == DROP && i_axis_tvalid) stat_drop_q <= sat_inc32(stat_drop_q);
      if (err_d) stat_err_q <= sat_inc16(stat_err_q);
    end
  end

  assign o_stat_pkts = stat_pkts_q;
  assign o_stat_drop = stat_drop_q;
  assign o_stat_err  = stat_err_q;
`endif

endmodule

// File: tb/tb_cam_line_pkt.sv
// Directed bench for cam_line_pkt: header contents, chunking at MAX_BEATS,
// back-pressure, dropped lines, mid-line SOF errors and mid-packet reset.
module tb_cam_line_pkt;

  localparam int MAXB = 128;

  logic        i_pclk = 1'b0;
  logic        i_prst;
  logic        i_enable;
  logic        i_axis_tvalid;
  logic        i_axis_tlast;
  logic [63:0] i_axis_tdata;
  logic [7:0]  i_axis_tkeep;
  logic [1:0]  i_axis_tuser;
  logic        o_axis_tready;
  logic        o_axis_tvalid;
  logic        o_axis_tlast;
  logic [63:0] o_axis_tdata;
  logic [7:0]  o_axis_tkeep;
  logic [1:0]  o_axis_tuser;
  logic        i_axis_tready;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_line_cnt;
  logic        o_err_sof;
`ifdef CAM_LINE_PKT_STATS_EN
  logic [31:0] o_stat_pkts;
  logic [31:0] o_stat_drop;
  logic [15:0] o_stat_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  cam_line_pkt #(.MAX_BEATS(MAXB), .CNT_W(16)) dut (
    .i_pclk(i_pclk), .i_prst(i_prst), .i_enable(i_enable),
    .i_axis_tvalid(i_axis_tvalid), .i_axis_tlast(i_axis_tlast),
    .i_axis_tdata(i_axis_tdata), .i_axis_tkeep(i_axis_tkeep),
    .i_axis_tuser(i_axis_tuser), .o_axis_tready(o_axis_tready),
    .o_axis_tvalid(o_axis_tvalid), .o_axis_tlast(o_axis_tlast),
    .o_axis_tdata(o_axis_tdata), .o_axis_tkeep(o_axis_tkeep),
    .o_axis_tuser(o_axis_tuser), .i_axis_tready(i_axis_tready),
    .o_frame_cnt(o_frame_cnt), .o_line_cnt(o_line_cnt),
`ifdef CAM_LINE_PKT_STATS_EN
    .o_stat_pkts(o_stat_pkts), .o_stat_drop(o_stat_drop), .o_stat_err(o_stat_err),
`endif
    .o_err_sof(o_err_sof)
  );

  always #5 i_pclk = ~i_pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int tag, input int i);
    return {16'(tag), 16'hBEEF, 32'(i)};
  endfunction

  function automatic logic [7:0] kpat(input int i);
    return 8'hFF >> (i % 4);
  endfunction

  // Drives one enabled line and checks every header and payload beat.
  // exp_frame/exp_line are the header indices expected for this line.
  task automatic run_line(input int n, input bit sof, input bit eof, input int err_beat,
                          input int abort_at, input logic [15:0] exp_frame,
                          input logic [15:0] exp_line, input bit rnd, input int tag,
                          output int npkts, output int last_size, output int nerr);
    int i, k, c, cyc;
    bit phase, done, exp_err, rdy;
    logic [63:0] exp_hdr;
    i = 0; k = 0; c = 0; cyc = 0; phase = 0; done = 0; exp_err = 0;
    npkts = 0; last_size = 0; nerr = 0;
    while (!done && cyc < 4 * n + 40) begin
      @(negedge i_pclk);
      cyc++;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_axis_tvalid = 1'b1;
      i_axis_tdata  = pat(tag, i);
      i_axis_tkeep  = kpat(i);
      i_axis_tlast  = (i == n - 1);
      i_axis_tuser  = {eof && (i == n - 1), (sof && i == 0) || (i == err_beat)};
      i_axis_tready = rdy;
      #1;
      chk("err_sof", o_err_sof, exp_err);
      exp_err = 0;
      if (!phase) begin
        if (o_axis_tvalid) begin
          exp_hdr = {exp_frame, exp_line, 16'(c), 14'd0, c != 0, sof && c == 0};
          chk("hdr_data", o_axis_tdata, exp_hdr);
          chk("hdr_user", o_axis_tuser, 2'b01);
          chk("hdr_keep", o_axis_tkeep, 8'hFF);
          chk("hdr_last", o_axis_tlast, 1'b0);
          chk("hdr_trdy", o_axis_tready, 1'b0);
          if (rdy) begin phase = 1; k = 0; npkts++; end
        end else begin
          chk("idle_trdy", o_axis_tready, 1'b0);
        end
      end else begin
        chk("pay_valid", o_axis_tvalid, 1'b1);
        chk("pay_data", o_axis_tdata, pat(tag, i));
        chk("pay_keep", o_axis_tkeep, kpat(i));
        chk("pay_user", o_axis_tuser, {eof && (i == n - 1), 1'b0});
        chk("pay_last", o_axis_tlast, (i == n - 1) || (k == MAXB - 1));
        chk("pay_trdy", o_axis_tready, rdy);
        if (rdy) begin
          if (i == err_beat && (k != 0 || c != 0)) begin exp_err = 1; nerr++; end
          if (i == abort_at) done = 1;
          i++; k++;
          if (i == n) begin done = 1; last_size = k; end
          else if (k == MAXB) begin c++; phase = 0; end
        end
      end
    end
    chk("line_done", done, 1'b1);
  endtask

  // Drives one line while disabled; no output beats may appear.
  task automatic drop_line(input int n, input bit sof, input bit eof, output int consumed);
    int cyc;
    consumed = 0; cyc = 0;
    while (consumed < n && cyc < 2 * n + 20) begin
      @(negedge i_pclk);
      cyc++;
      i_enable      = 1'b0;
      i_axis_tvalid = 1'b1;
      i_axis_tdata  = pat(99, consumed);
      i_axis_tkeep  = 8'hFF;
      i_axis_tlast  = (consumed == n - 1);
      i_axis_tuser  = {eof && (consumed == n - 1), sof && consumed == 0};
      i_axis_tready = 1'b1;
      #1;
      chk("drop_ovalid", o_axis_tvalid, 1'b0);
      if (o_axis_tready) consumed++;
    end
  endtask

  task automatic idle_check(input string tag, input logic [15:0] f, input logic [15:0] l);
    @(negedge i_pclk);
    i_axis_tvalid = 1'b0;
    i_axis_tlast  = 1'b0;
    i_axis_tuser  = 2'b00;
    #1;
    chk({tag, "_frame"}, o_frame_cnt, f);
    chk({tag, "_line"}, o_line_cnt, l);
  endtask

  initial begin
    int np, ls, ne, cons;
    int pk_total, err_total;
    i_prst = 1'b1; i_enable = 1'b1; i_axis_tvalid = 1'b0; i_axis_tlast = 1'b0;
    i_axis_tdata = '0; i_axis_tkeep = '0; i_axis_tuser = '0; i_axis_tready = 1'b1;
    repeat (2) @(posedge i_pclk);
    @(negedge i_pclk);
    #1;
    chk("rst_trdy", o_axis_tready, 1'b0);
    chk("rst_tvalid", o_axis_tvalid, 1'b0);
    chk("rst_frame", o_frame_cnt, 16'd0);
    chk("rst_line", o_line_cnt, 16'd0);
    chk("rst_err", o_err_sof, 1'b0);
    i_prst = 1'b0;

    // 3-beat line with SOF and EOF: header 0x...0001
    run_line(3, 1, 1, -1, -1, 16'd0, 16'd0, 0, 1, np, ls, ne);
    chk("l3_pkts", np, 1);
    chk("l3_size", ls, 3);
    idle_check("l3", 16'd0, 16'd0);

    // 300-beat line: chunks of 128, 128, 44 in frame 1
    run_line(300, 1, 0, -1, -1, 16'd1, 16'd0, 0, 2, np, ls, ne);
    chk("l300_pkts", np, 3);
    chk("l300_last", ls, 44);
    idle_check("l300", 16'd1, 16'd1);

    // Disabled line with SOF: consumed silently, indices still track
    drop_line(5, 1, 0, cons);
    chk("drop_cons", cons, 5);
    idle_check("drop", 16'd2, 16'd1);
    i_enable = 1'b1;
    run_line(4, 0, 0, -1, -1, 16'd2, 16'd1, 0, 3, np, ls, ne);
    chk("after_drop_pkts", np, 1);
    idle_check("after_drop", 16'd2, 16'd2);

    // 10-line frame with random downstream ready
    pk_total = 0;
    for (int l = 0; l < 10; l++) begin
      run_line(5 + l, l == 0, l == 9, -1, -1, 16'd3, 16'(l), 1, 10 + l, np, ls, ne);
      pk_total += np;
    end
    chk("frm_pkts", pk_total, 10);
    idle_check("frm", 16'd3, 16'd0);

    // SOF on beat 4: one error pulse, frame index unchanged
    i_axis_tready = 1'b1;
    run_line(8, 1, 0, 4, -1, 16'd4, 16'd0, 0, 30, np, ls, ne);
    err_total = ne;
    @(negedge i_pclk);
    i_axis_tvalid = 1'b0;
    #1;
    chk("err_count", err_total, 1);
    chk("err_frame", o_frame_cnt, 16'd4);
    chk("err_line", o_line_cnt, 16'd1);
    chk("err_pulse_gone", o_err_sof, 1'b0);

    // Exactly MAX_BEATS: one packet, no empty trailing chunk
    run_line(128, 0, 0, -1, -1, 16'd4, 16'd1, 0, 31, np, ls, ne);
    chk("l128_pkts", np, 1);
    chk("l128_size", ls, 128);
    idle_check("l128", 16'd4, 16'd2);

    // Exact multiple of MAX_BEATS: two full packets
    run_line(256, 0, 0, -1, -1, 16'd4, 16'd2, 0, 32, np, ls, ne);
    chk("l256_pkts", np, 2);
    chk("l256_size", ls, 128);
    idle_check("l256", 16'd4, 16'd3);

    // Reset in the middle of a packet
    run_line(10, 0, 0, -1, 3, 16'd4, 16'd3, 0, 33, np, ls, ne);
    i_prst = 1'b1;
    @(negedge i_pclk);
    i_prst = 1'b0;
    i_axis_tvalid = 1'b0;
    #1;
    chk("mrst_trdy", o_axis_tready, 1'b0);
    chk("mrst_tvalid", o_axis_tvalid, 1'b0);
    chk("mrst_tlast", o_axis_tlast, 1'b0);
    chk("mrst_tdata", o_axis_tdata, 64'd0);
    chk("mrst_tkeep", o_axis_tkeep, 8'd0);
    chk("mrst_tuser", o_axis_tuser, 2'd0);
    chk("mrst_frame", o_frame_cnt, 16'd0);
    chk("mrst_line", o_line_cnt, 16'd0);
    chk("mrst_err", o_err_sof, 1'b0);
    run_line(2, 1, 1, -1, -1, 16'd0, 16'd0, 0, 40, np, ls, ne);
    chk("post_rst_pkts", np, 1);
    idle_check("post_rst", 16'd0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
